fetch_unit: RTL and testbench

//  Parametrised fetch stage: owns the PC and issues word-aligned read requests to instruction memory

---
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: PC, credit-limited memory requests, in-order instruction buffer
// Responses return in order; stale ones after a redirect are counted off via r_drop.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              IBUF_DEPTH = 4,
    parameter logic [4:0]      DATA_TAG   = 5'h1F
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt,
    input  logic            redirect_vld,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_vld,
    input  logic            req_rdy,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_vld,
    input  logic [XLEN-1:0] rsp_data,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [XLEN-1:0] out_word,
    output logic [XLEN-1:0] out_pc,
    output logic            out_is_data,
    output logic            busy
);
    localparam int AW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(IBUF_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_HALTD = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_aq [IBUF_DEPTH];
    logic [AW-1:0]   r_aq_wr;
    logic [AW-1:0]   r_aq_rd;
    logic [XLEN-1:0] r_buf_word [IBUF_DEPTH];
    logic [XLEN-1:0] r_buf_pc [IBUF_DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_drop;
    logic [XLEN-1:0] r_hold_word;
    logic [XLEN-1:0] r_hold_pc;

    logic            w_credit;
    logic            w_fire;
    logic            w_rsp_acc;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_outst_nxt;
    logic [XLEN-1:0] w_head_word;
    logic [XLEN-1:0] w_head_pc;
    logic            w_unused_redirect;

    assign w_unused_redirect = ^redirect_pc[1:0];

    // Buffered words plus outstanding requests never exceed the buffer size,
    // so a response always finds a free slot and rsp needs no back-pressure.
    assign w_credit    = (({1'b0, r_count} + {1'b0, r_outst}) < DEPTH_C);
    assign req_vld     = (r_state == S_RUN) && w_credit && !redirect_vld;
    assign req_addr    = r_pc;
    assign w_fire      = req_vld && req_rdy;
    assign w_rsp_acc   = rsp_vld && (r_outst != '0);
    assign w_push      = w_rsp_acc && (r_drop == '0) && !redirect_vld;
    assign w_pop       = out_vld && out_rdy && !redirect_vld;
    assign w_outst_nxt = r_outst + CW'(w_fire) - CW'(w_rsp_acc);

    assign w_head_word = r_buf_word[r_head];
    assign w_head_pc   = r_buf_pc[r_head];
    assign out_vld     = (r_count != '0);
    assign out_word    = out_vld ? w_head_word : r_hold_word;
    assign out_pc      = out_vld ? w_head_pc : r_hold_pc;
    assign out_is_data = out_vld && (w_head_word[4:0] == DATA_TAG);
    assign busy        = (r_outst != '0) || (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   if (halt) w_state_nxt = S_HALTD;
            S_HALTD: if (!halt) w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_aq[r_aq_wr] <= r_pc;
        end
        if (w_push) begin
            r_buf_word[r_tail] <= rsp_data;
            r_buf_pc[r_tail]   <= r_aq[r_aq_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc        <= RESET_PC;
            r_aq_wr     <= '0;
            r_aq_rd     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_outst     <= '0;
            r_drop      <= '0;
            r_hold_word <= '0;
            r_hold_pc   <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (out_vld) begin
                r_hold_word <= w_head_word;
                r_hold_pc   <= w_head_pc;
            end
            if (redirect_vld) begin
                // Everything still in flight now belongs to the old stream.
                r_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
                r_aq_rd <= r_aq_wr;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_drop  <= w_outst_nxt;
            end else begin
                if (w_fire) begin
                    r_pc    <= r_pc + XLEN'(4);
                    r_aq_wr <= r_aq_wr + AW'(1);
                end
                if (w_rsp_acc) begin
                    if (r_drop != '0) begin
                        r_drop <= r_drop - CW'(1);
                    end else begin
                        r_aq_rd <= r_aq_rd + AW'(1);
                    end
                end
                if (w_push) begin
                    r_tail <= r_tail + AW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit with a queue-based reference model
module tb_fetch_unit;
    localparam int          D   = 4;
    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    logic        rst, halt, redirect_vld, req_rdy, rsp_vld, out_rdy;
    logic [31:0] redirect_pc, rsp_data, req_addr, out_word, out_pc;
    logic        req_vld, out_vld, out_is_data, busy;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (RPC),
        .IBUF_DEPTH (D),
        .DATA_TAG   (5'h1F)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .halt         (halt),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_addr     (req_addr),
        .rsp_vld      (rsp_vld),
        .rsp_data     (rsp_data),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_word     (out_word),
        .out_pc       (out_pc),
        .out_is_data  (out_is_data),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: each in-flight request is a queue entry marked stale on redirect.
    typedef struct { logic [31:0] pc; bit stale; } fl_t;
    typedef struct { logic [31:0] word; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] addr; int ready; } mreq_t;

    fl_t         m_fl[$];
    ent_t        m_buf[$];
    logic [31:0] m_pc, m_last_word, m_last_pc, m_fire_addr;
    int          m_mode;
    bit          m_init = 1'b0;
    bit          m_fired = 1'b0;

    mreq_t mq[$];
    int    cyc = 0;
    int    lat_min = 1, lat_max = 1, mem_pct = 100, spur_pct = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a == 32'h3000) return 32'h0000001F;
        if (a == 32'h3004) return 32'h00000013;
        w = a * 32'h9E3779B1;
        if (a[4:2] == 3'b101) w[4:0] = 5'h1F;
        return w;
    endfunction

    task automatic cycle();
        bit          e_req_vld, e_out_vld, acc;
        bit          s_rst, s_halt, s_redir, s_req_rdy, s_rsp, s_out_rdy;
        logic [31:0] s_rpc, s_rdata;
        fl_t         f;
        e_req_vld = 1'b0;
        e_out_vld = 1'b0;
        @(negedge clk);
        if (mq.size() > 0 && mq[0].ready <= cyc && $urandom_range(99) < mem_pct) begin
            rsp_vld  = 1'b1;
            rsp_data = mem_word(mq[0].addr);
        end else if (mq.size() == 0 && $urandom_range(99) < spur_pct) begin
            rsp_vld  = 1'b1;
            rsp_data = $urandom;
        end else begin
            rsp_vld  = 1'b0;
            rsp_data = $urandom;
        end
        #1;
        s_rst = rst; s_halt = halt; s_redir = redirect_vld; s_req_rdy = req_rdy;
        s_rsp = rsp_vld; s_out_rdy = out_rdy; s_rpc = redirect_pc; s_rdata = rsp_data;
        if (m_init) begin
            e_req_vld = (m_mode == 1) && ((m_buf.size() + m_fl.size()) < D) && !s_redir;
            e_out_vld = (m_buf.size() > 0);
            chk("req_vld", req_vld, e_req_vld);
            chk("req_addr", req_addr, m_pc);
            chk("out_vld", out_vld, e_out_vld);
            chk("out_word", out_word, e_out_vld ? m_buf[0].word : m_last_word);
            chk("out_pc", out_pc, e_out_vld ? m_buf[0].pc : m_last_pc);
            chk("out_is_data", out_is_data, e_out_vld && (m_buf[0].word[4:0] == 5'h1F));
            chk("busy", busy, (m_fl.size() + m_buf.size()) != 0);
        end
        @(posedge clk);
        if (!s_rst) begin
            mq.delete();
        end else begin
            if (s_rsp && mq.size() > 0) void'(mq.pop_front());
            if (e_req_vld && s_req_rdy) mq.push_back('{m_pc, cyc + int'($urandom_range(lat_max, lat_min))});
        end
        if (!s_rst) begin
            m_pc = RPC; m_fl.delete(); m_buf.delete(); m_mode = 0;
            m_last_word = '0; m_last_pc = '0; m_init = 1'b1; m_fired = 1'b0;
        end else begin
            acc     = s_rsp && (m_fl.size() > 0);
            m_fired = e_req_vld && s_req_rdy;
            if (e_out_vld) begin
                m_last_word = m_buf[0].word;
                m_last_pc   = m_buf[0].pc;
            end
            if (s_redir) begin
                if (acc) void'(m_fl.pop_front());
                foreach (m_fl[i]) m_fl[i].stale = 1'b1;
                m_buf.delete();
                m_pc = {s_rpc[31:2], 2'b00};
            end else begin
                if (e_out_vld && s_out_rdy) void'(m_buf.pop_front());
                if (acc) begin
                    f = m_fl.pop_front();
                    if (!f.stale) m_buf.push_back('{s_rdata, f.pc});
                end
                if (m_fired) begin
                    m_fire_addr = m_pc;
                    m_fl.push_back('{m_pc, 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
            case (m_mode)
                0: m_mode = 1;
                1: if (s_halt) m_mode = 2;
                default: if (!s_halt) m_mode = 1;
            endcase
        end
        cyc++;
        #1;
    endtask

    int          fires, first_fire_cyc, first_out_cyc;
    bit          seen_out;
    logic [31:0] first_out_pc;
    logic [31:0] fa[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; halt = 1'b0; redirect_vld = 1'b0; redirect_pc = '0;
        req_rdy = 1'b1; out_rdy = 1'b1; rsp_vld = 1'b0; rsp_data = '0;
        cycle(); cycle();
        chk("rst_req_addr", req_addr, 32'h100);
        chk("rst_out_vld", out_vld, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_vld", req_vld, 1'b0);

        // Sequential fetch, out_pc two cycles behind req_addr
        rst = 1'b1; seen_out = 1'b0; first_fire_cyc = 0; first_out_cyc = 0; first_out_pc = '0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (m_fired) begin
                if (fa.size() == 0) first_fire_cyc = cyc - 1;
                fa.push_back(m_fire_addr);
            end
            if (out_vld && !seen_out) begin
                seen_out = 1'b1; first_out_cyc = cyc; first_out_pc = out_pc;
            end
            if (fa.size() >= 3 && seen_out) break;
        end
        chk("t1_nfires", fa.size() >= 3, 1'b1);
        while (fa.size() < 3) fa.push_back('x);
        chk("t1_addr0", fa[0], 32'h100);
        chk("t1_addr1", fa[1], 32'h104);
        chk("t1_addr2", fa[2], 32'h108);
        chk("t1_seen_out", seen_out, 1'b1);
        chk("t1_out_pc", first_out_pc, 32'h100);
        chk("t1_lag", first_out_cyc - first_fire_cyc, 2);

        // Decode stalled: exactly D requests, then drain in order
        rst = 1'b0; cycle(); rst = 1'b1; out_rdy = 1'b0; fires = 0;
        repeat (20) begin cycle(); if (m_fired) fires++; end
        chk("t2_fires", fires, D);
        chk("t2_req_vld", req_vld, 1'b0);
        out_rdy = 1'b1;
        for (int i = 0; i < D; i++) begin
            chk("t2_drain_pc", out_pc, 32'h100 + 32'(4 * i));
            cycle();
        end
        fires = 0;
        repeat (5) begin cycle(); if (m_fired) fires++; end
        chk("t2_resume", fires > 0, 1'b1);

        // Redirect with 3 outstanding
        rst = 1'b0; cycle(); rst = 1'b1; mem_pct = 0; fires = 0;
        for (int i = 0; i < 20 && fires < 3; i++) begin cycle(); if (m_fired) fires++; end
        req_rdy = 1'b0;
        chk("t3_outst", fires, 3);
        redirect_vld = 1'b1; redirect_pc = 32'h2003; req_rdy = 1'b1;
        cycle();
        redirect_vld = 1'b0;
        chk("t3_req_addr", req_addr, 32'h2000);
        chk("t3_busy", busy, 1'b1);
        mem_pct = 100;
        for (int i = 0; i < 30 && !out_vld; i++) cycle();
        chk("t3_out_pc", out_pc, 32'h2000);

        // Data-word tagging
        out_rdy = 1'b0; redirect_vld = 1'b1; redirect_pc = 32'h3000;
        cycle();
        redirect_vld = 1'b0;
        repeat (12) cycle();
        chk("t4_word0", out_word, 32'h1F);
        chk("t4_is_data0", out_is_data, 1'b1);
        out_rdy = 1'b1; cycle(); out_rdy = 1'b0;
        chk("t4_word1", out_word, 32'h13);
        chk("t4_pc1", out_pc, 32'h3004);
        chk("t4_is_data1", out_is_data, 1'b0);

        // PC wrap, then halt
        out_rdy = 1'b1; redirect_vld = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_vld = 1'b0; m_fired = 1'b0;
        for (int i = 0; i < 20 && !m_fired; i++) cycle();
        chk("t5_wrap_fired", m_fired, 1'b1);
        chk("t5_wrap_addr", req_addr, 32'h0);
        halt = 1'b1; out_rdy = 1'b0;
        cycle();
        fires = 0;
        repeat (10) begin cycle(); if (m_fired) fires++; end
        chk("t5_halt_fires", fires, 0);
        chk("t5_halt_req_vld", req_vld, 1'b0);
        chk("t5_halt_buffered", out_vld, 1'b1);
        halt = 1'b0;

        // Reset while busy
        repeat (12) cycle();
        chk("t6_busy_before", busy, 1'b1);
        rst = 1'b0; cycle(); rst = 1'b1;
        chk("t6_out_vld", out_vld, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_req_addr", req_addr, 32'h100);

        // Random traffic
        lat_min = 1; lat_max = 4; mem_pct = 70; spur_pct = 20;
        repeat (3000) begin
            rst          = ($urandom_range(499) != 0);
            halt         = ($urandom_range(19) == 0) ? ~halt : halt;
            redirect_vld = ($urandom_range(29) == 0);
            redirect_pc  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(15)) : $urandom;
            req_rdy      = ($urandom_range(3) != 0);
            out_rdy      = ($urandom_range(2) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
